// File: rtl/pwm_ramp_pkg.sv
// pwm_ramp_pkg
// Shared constants for the multi-channel PWM / duty-ramp controller:
//   - per-channel mode encodings (2 bits per channel on the top-level mode bus)
//   - sweep direction encodings
//   - a counter-width helper that never returns zero
package pwm_ramp_pkg;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_STEP  = 2'b01;
    localparam logic [1:0] MODE_SWEEP = 2'b10;
    localparam logic [1:0] MODE_ZERO  = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Width needed to hold 0..n-1, at least one bit so n=1 still builds.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/pwm_ramp_chan.sv
// pwm_ramp_chan
// One PWM channel: working duty engine (hold / step / sweep / zero), shadow
// duty reloaded at period start, and a registered PWM comparator.
// Ports:
//   clk, rstp      clock, async active-high reset
//   mode[1:0]      channel mode (see pwm_ramp_pkg)
//   step_up/dn     single-cycle step pulses (STEP mode only)
//   tick           shared sweep tick (SWEEP mode only)
//   period_start   strobe in the cycle the shared period counter wraps to 0
//   pcnt           shared period counter
//   pwm            registered PWM output
//   duty           working duty
//   dir            sweep direction (0 up, 1 down)
module pwm_ramp_chan
    import pwm_ramp_pkg::*;
#(
    parameter int DUTY_MAX = 100,
    parameter int DUTY_W   = 7,
    parameter int SWEEP_LO = 10,
    parameter int SWEEP_HI = 100
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic [1:0]        mode,
    input  logic              step_up,
    input  logic              step_dn,
    input  logic              tick,
    input  logic              period_start,
    input  logic [DUTY_W-1:0] pcnt,
    output logic              pwm,
    output logic [DUTY_W-1:0] duty,
    output logic              dir
);

    localparam logic [DUTY_W-1:0] D_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] D_LO   = DUTY_W'(SWEEP_LO);
    localparam logic [DUTY_W-1:0] D_HI   = DUTY_W'(SWEEP_HI);
    localparam logic [DUTY_W-1:0] D_ONE  = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] D_ZERO = DUTY_W'(0);

    logic [DUTY_W-1:0] duty_nxt;
    logic              dir_nxt;
    logic [DUTY_W-1:0] shadow;

    // Next working duty and direction for the current mode.
    always_comb begin
        duty_nxt = duty;
        dir_nxt  = dir;
        case (mode)
            MODE_HOLD: begin
                duty_nxt = duty;
                dir_nxt  = dir;
            end
            MODE_STEP: begin
                // Simultaneous up and down cancel out.
                if (step_up && !step_dn) begin
                    if (duty < D_MAX) duty_nxt = duty + D_ONE;
                    else              duty_nxt = duty;
                end else if (step_dn && !step_up) begin
                    if (duty > D_ZERO) duty_nxt = duty - D_ONE;
                    else               duty_nxt = duty;
                end else begin
                    duty_nxt = duty;
                end
            end
            MODE_SWEEP: begin
                // Out-of-band duties are pulled back toward the band first;
                // at a bound the turnaround and the step share one tick.
                if (tick) begin
                    if (duty < D_LO) begin
                        dir_nxt  = DIR_UP;
                        duty_nxt = duty + D_ONE;
                    end else if (duty > D_HI) begin
                        dir_nxt  = DIR_DOWN;
                        duty_nxt = duty - D_ONE;
                    end else if (dir == DIR_UP && duty == D_HI) begin
                        dir_nxt  = DIR_DOWN;
                        duty_nxt = duty - D_ONE;
                    end else if (dir == DIR_DOWN && duty == D_LO) begin
                        dir_nxt  = DIR_UP;
                        duty_nxt = duty + D_ONE;
                    end else if (dir == DIR_UP) begin
                        duty_nxt = duty + D_ONE;
                    end else begin
                        duty_nxt = duty - D_ONE;
                    end
                end else begin
                    duty_nxt = duty;
                end
            end
            MODE_ZERO: begin
                duty_nxt = D_ZERO;
                dir_nxt  = DIR_UP;
            end
            default: begin
                duty_nxt = duty;
                dir_nxt  = dir;
            end
        endcase
    end

    // Working duty, direction, shadow duty and registered PWM output.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            duty   <= D_ZERO;
            dir    <= DIR_UP;
            shadow <= D_ZERO;
            pwm    <= 1'b0;
        end else begin
            duty <= duty_nxt;
            dir  <= dir_nxt;
            if (period_start) shadow <= duty;
            // Shadow of DUTY_MAX keeps pcnt < shadow true across the wrap.
            pwm <= (pcnt < shadow);
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// Multi-channel PWM generator with per-channel duty engines.
// Shared prescaler / period counter / ramp tick feed CH pwm_ramp_chan
// instances; the selected channel's working duty is exported registered.
// Ports:
//   clk        system clock
//   rstp       async active-high reset
//   mode       2 bits per channel, channel k at [2k+1:2k]
//   step_up    per-channel increment pulses
//   step_dn    per-channel decrement pulses
//   sel        display channel select (out-of-range reads channel 0)
//   pwm        per-channel PWM outputs (registered)
//   duty_sel   working duty of channel sel, one cycle late
//   dir        per-channel sweep direction
module pwm_ramp_ctrl
    import pwm_ramp_pkg::*;
#(
    parameter int CH        = 2,
    parameter int DUTY_MAX  = 100,
    parameter int DUTY_W    = 7,
    parameter int SWEEP_LO  = 10,
    parameter int SWEEP_HI  = 100,
    parameter int PWM_PRESC = 10000,
    parameter int RAMP_DIV  = 2097152,
    parameter int SEL_W     = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rstp,
    input  logic [2*CH-1:0]   mode,
    input  logic [CH-1:0]     step_up,
    input  logic [CH-1:0]     step_dn,
    input  logic [SEL_W-1:0]  sel,
    output logic [CH-1:0]     pwm,
    output logic [DUTY_W-1:0] duty_sel,
    output logic [CH-1:0]     dir
);

    localparam int PW = cnt_w(PWM_PRESC);
    localparam int RW = cnt_w(RAMP_DIV);

    logic [PW-1:0]              presc;
    logic [DUTY_W-1:0]          pcnt;
    logic [RW-1:0]              ramp;
    logic                       presc_wrap;
    logic                       period_start;
    logic                       tick;
    logic [CH-1:0][DUTY_W-1:0]  duty_all;
    logic [DUTY_W-1:0]          sel_duty;

    assign presc_wrap   = (presc == PW'(PWM_PRESC - 1));
    assign period_start = presc_wrap && (pcnt == DUTY_W'(DUTY_MAX - 1));
    assign tick         = (ramp == RW'(RAMP_DIV - 1));

    // Prescaler, period counter and sweep ramp counter.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) begin
            presc <= '0;
            pcnt  <= '0;
            ramp  <= '0;
        end else begin
            presc <= presc_wrap ? PW'(0) : presc + PW'(1);
            if (period_start)    pcnt <= DUTY_W'(0);
            else if (presc_wrap) pcnt <= pcnt + DUTY_W'(1);
            else                 pcnt <= pcnt;
            ramp <= tick ? RW'(0) : ramp + RW'(1);
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_chan
        pwm_ramp_chan #(
            .DUTY_MAX (DUTY_MAX),
            .DUTY_W   (DUTY_W),
            .SWEEP_LO (SWEEP_LO),
            .SWEEP_HI (SWEEP_HI)
        ) u_chan (
            .clk          (clk),
            .rstp         (rstp),
            .mode         (mode[2*k +: 2]),
            .step_up      (step_up[k]),
            .step_dn      (step_dn[k]),
            .tick         (tick),
            .period_start (period_start),
            .pcnt         (pcnt),
            .pwm          (pwm[k]),
            .duty         (duty_all[k]),
            .dir          (dir[k])
        );
    end

    // Display channel mux; out-of-range selects fall back to channel 0.
    always_comb begin
        sel_duty = duty_all[0];
        if (int'(sel) < CH) sel_duty = duty_all[sel];
        else                sel_duty = duty_all[0];
    end

    // Registered display duty.
    always_ff @(posedge clk or posedge rstp) begin
        if (rstp) duty_sel <= '0;
        else      duty_sel <= sel_duty;
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed self-checking bench for pwm_ramp_ctrl with a small configuration:
// DUTY_MAX=10, PWM_PRESC=2 (20-clk period), RAMP_DIV=8, sweep band 2..8.
module tb_pwm_ramp_ctrl;

    localparam int CH = 2;
    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          rstp;
    logic [3:0]    mode;
    logic [1:0]    step_up;
    logic [1:0]    step_dn;
    logic [0:0]    sel;
    logic [1:0]    pwm;
    logic [DW-1:0] duty_sel;
    logic [1:0]    dir;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hc0      = 0;
    int hc1      = 0;

    pwm_ramp_ctrl #(
        .CH        (CH),
        .DUTY_MAX  (10),
        .DUTY_W    (DW),
        .SWEEP_LO  (2),
        .SWEEP_HI  (8),
        .PWM_PRESC (2),
        .RAMP_DIV  (8)
    ) dut (
        .clk      (clk),
        .rstp     (rstp),
        .mode     (mode),
        .step_up  (step_up),
        .step_dn  (step_dn),
        .sel      (sel),
        .pwm      (pwm),
        .duty_sel (duty_sel),
        .dir      (dir)
    );

    always #5 clk = ~clk;

    // One clock: sample 1 time unit after the edge and accumulate pwm highs.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        hc0 = hc0 + int'(pwm[0]);
        hc1 = hc1 + int'(pwm[1]);
    endtask

    // Advance to just after the next period-start edge (cyc multiple of 20).
    task automatic align();
        do cycle(); while (cyc % 20 != 0);
    endtask

    task automatic pulse(input logic [1:0] up, input logic [1:0] dn);
        step_up = up;
        step_dn = dn;
        cycle();
        step_up = 2'b00;
        step_dn = 2'b00;
        cycle();
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int exp_duty [15] = '{1, 2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4, 3, 2, 3};
    int exp_dir  [15] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        rstp    = 1'b1;
        mode    = 4'b0000;
        step_up = 2'b00;
        step_dn = 2'b00;
        sel     = 1'b0;
        cycle();
        cycle();
        check("reset_pwm", int'(pwm), 0);
        check("reset_duty_sel", int'(duty_sel), 0);
        check("reset_dir", int'(dir), 0);
        rstp = 1'b0;
        cyc  = 0;

        // STEP on channel 0: three increments, display lags one cycle.
        mode = 4'b0101;
        pulse(2'b01, 2'b00);
        pulse(2'b01, 2'b00);
        step_up = 2'b01;
        cycle();
        check("sel_lag", int'(duty_sel), 2);
        step_up = 2'b00;
        cycle();
        check("step_up3", int'(duty_sel), 3);
        pulse(2'b01, 2'b01);
        check("up_dn_cancel", int'(duty_sel), 3);

        // Load channel 1 to 5, then freeze it.
        for (int i = 0; i < 5; i++) pulse(2'b10, 2'b00);
        mode = 4'b0001;
        pulse(2'b10, 2'b10);

        align();
        hc0 = 0; hc1 = 0;
        repeat (20) cycle();
        check("pwm0_width3", hc0, 6);
        check("pwm1_width5", hc1, 10);

        // Saturate high.
        for (int i = 0; i < 8; i++) pulse(2'b01, 2'b00);
        check("sat_hi", int'(duty_sel), 10);
        align();
        hc0 = 0;
        repeat (40) cycle();
        check("pwm0_const_hi", hc0, 40);

        // Saturate low.
        for (int i = 0; i < 11; i++) pulse(2'b00, 2'b01);
        check("sat_lo", int'(duty_sel), 0);
        align();
        hc0 = 0;
        repeat (20) cycle();
        check("pwm0_const_lo", hc0, 0);

        // SWEEP on channel 0 with step pulses held active (must be ignored).
        mode    = 4'b0010;
        step_up = 2'b11;
        for (int i = 0; i < 15; i++) begin
            do cycle(); while (cyc % 8 != 0);
            cycle();
            check($sformatf("sweep_duty_%0d", i), int'(duty_sel), exp_duty[i]);
            check($sformatf("sweep_dir_%0d", i), int'(dir[0]), exp_dir[i]);
        end
        check("hold_dir1", int'(dir[1]), 0);
        step_up = 2'b00;

        // Back to STEP on channel 0 before the next tick; display channel 1.
        mode = 4'b0001;
        sel  = 1'b1;
        cycle();
        check("sel_ch1", int'(duty_sel), 5);
        sel = 1'b0;
        cycle();
        check("sel_ch0", int'(duty_sel), 3);

        // Mid-period duty change keeps the current width.
        align();
        hc0 = 0; hc1 = 0;
        repeat (10) cycle();
        pulse(2'b01, 2'b00);
        pulse(2'b01, 2'b00);
        while (cyc % 20 != 0) cycle();
        check("midchg_same", hc0, 6);
        check("hold_pwm1", hc1, 10);
        hc0 = 0;
        repeat (20) cycle();
        check("midchg_next", hc0, 10);

        // ZERO mid-period: width holds this period, zero from the next.
        hc0 = 0;
        repeat (5) cycle();
        mode = 4'b0011;
        cycle();
        cycle();
        check("zero_duty", int'(duty_sel), 0);
        while (cyc % 20 != 0) cycle();
        check("zero_this_period", hc0, 10);
        hc0 = 0;
        repeat (20) cycle();
        check("zero_next_period", hc0, 0);
        check("zero_dir", int'(dir[0]), 0);

        // Reset mid-period.
        mode = 4'b0000;
        sel  = 1'b1;
        repeat (3) cycle();
        check("pre_rst_pwm1", int'(pwm[1]), 1);
        rstp = 1'b1;
        #1;
        check("rst_pwm_async", int'(pwm), 0);
        check("rst_duty_sel", int'(duty_sel), 0);
        cycle();
        cycle();
        rstp = 1'b0;
        cyc  = 0;
        cycle();
        cycle();
        check("rst_ch1_duty", int'(duty_sel), 0);
        hc1 = 0;
        repeat (20) cycle();
        check("rst_pwm1_low", hc1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Multi-channel PWM generator with a per-channel duty engine. Each channel's duty is held, stepped by pulses, swept as a triangle between two bounds, or forced to zero. It replaces single-channel, fixed-sweep motor/LED drive tops. It sits between the debounced/edge-detected button logic and the motor or LED pins, and exports the selected channel's duty for the BCD/FND display path.

## Interface
- CH, 2: number of independent channels.
- DUTY_MAX, 100: full-scale duty; legal duty range is 0..DUTY_MAX.
- DUTY_W, 7: duty width; must satisfy 2^DUTY_W > DUTY_MAX.
- SWEEP_LO, 10: lower sweep bound.
- SWEEP_HI, 100: upper sweep bound; requires SWEEP_LO < SWEEP_HI ≤ DUTY_MAX.
- PWM_PRESC, 10000: clk cycles per PWM counter step. At 100 MHz with DUTY_MAX=100 this gives a 100 Hz PWM.
- RAMP_DIV, 2097152: clk cycles per sweep tick.
- clk  in  1  system clock; the only clock.
- rstp  in  1  reset, asynchronous, active-high.
- mode  in  2*CH  per-channel mode, channel k at [2k+1:2k]: 00 HOLD, 01 STEP, 10 SWEEP, 11 ZERO.
- step_up  in  CH  single-cycle increment pulses, already edge-detected.
- step_dn  in  CH  single-cycle decrement pulses.
- sel  in  max(1,$clog2(CH))  channel selected for display.
- pwm  out  CH  PWM outputs.
- duty_sel  out  DUTY_W  working duty of channel sel.
- dir  out  CH  sweep direction per channel; 0 = up, 1 = down.

## Operation
- Prescaler counts 0..PWM_PRESC-1. Its wrap strobe advances a shared period counter pcnt over 0..DUTY_MAX-1.
- Period start is the cycle in which pcnt wraps to 0. At period start each channel copies its working duty into a shadow duty.
- pwm[k] = (pcnt < shadow[k]). Shadow 0 gives constant low; shadow DUTY_MAX gives constant high, with no glitch at the period boundary.
- The ramp counter counts 0..RAMP_DIV-1 and emits a one-cycle tick on wrap. The tick is shared by all channels.
- HOLD: working duty and dir are frozen; step pulses are ignored.
- STEP:
  - step_up adds 1, saturating at DUTY_MAX.
  - step_dn subtracts 1, saturating at 0.
  - Both asserted in the same cycle: no change.
  - A tick has no effect.
- SWEEP, on tick only:
  - If duty < SWEEP_LO: dir←0 and duty+1.
  - Else if duty > SWEEP_HI: dir←1 and duty−1.
  - Else if dir=0 and duty=SWEEP_HI: dir←1 and duty−1.
  - Else if dir=1 and duty=SWEEP_LO: dir←0 and duty+1.
  - Otherwise duty steps by ±1 per dir.
  - Turnaround and step happen on the same tick, with no dwell: …99,100,99… and …11,10,11….
  - Step pulses are ignored.
- ZERO: working duty←0 on the next clk and dir←0, regardless of tick. The output reaches 0 at the next period start.
- Mode changes take effect in the cycle after mode changes. Working duty carries over unchanged between HOLD, STEP and SWEEP.
- duty_sel is registered, one cycle behind the working duty of channel sel. A sel value ≥ CH reads channel 0.

## Timing
- Reset (async assert, synchronous release via the clk domain) sets:
  - all counters, working and shadow duties, dir, and duty_sel to 0;
  - pwm to 0.
- After reset release, the first period start occurs PWM_PRESC*DUTY_MAX cycles later; the tick occurs RAMP_DIV cycles later.
- Latency:
  - step pulse or tick → working duty: 1 cycle;
  - working duty → pwm: at the next period start, then 1 cycle registered.
- pwm is driven from a flop; no combinational path from inputs to pwm.
- rstp mid-period forces pwm low immediately and restarts both counters.

## Structure
- Package pwm_ramp_pkg holds the mode localparams (MODE_HOLD, MODE_STEP, MODE_SWEEP, MODE_ZERO) and the DIR_UP/DIR_DOWN constants.
- Sub-module pwm_ramp_chan, instantiated CH times via generate:
  - inputs: mode, step pulses, tick, period-start strobe, shared pcnt;
  - outputs: pwm bit, working duty, dir.
- The prescaler, period counter, ramp counter and sel mux live in the top.

## Test plan
- Use bench parameters DUTY_MAX=10, PWM_PRESC=2, RAMP_DIV=8, SWEEP_LO=2, SWEEP_HI=8.
- Reset, then STEP on channel 0, 3 step_up pulses → duty_sel=3 one cycle after the third pulse; pwm[0] high for exactly 6 clk of each 20-clk period, starting at the next period start.
- STEP at duty 10, step_up → duty stays 10 and pwm constant high. At duty 0, step_dn → stays 0 and pwm constant low. step_up and step_dn together → unchanged.
- SWEEP from duty 0 → sequence 1,2,…,8,7,…,2,3 on successive ticks; dir toggles on the ticks that leave 8 and leave 2.
- Channel 0 in SWEEP with channel 1 in HOLD at duty 5 → channel 1 duty stays 5 and pwm[1] is high 10 of 20 clk. Toggling sel switches duty_sel one cycle later.
- Duty changed mid-period → pwm width of the current period unchanged; the new width appears from the next period start. ZERO → pwm low from the next period start. rstp pulsed mid-period → pwm low within the same cycle and all duties 0.
